// File: rtl/serial_shifter_param.sv
// Parallel-to-serial converter with a one-word holding buffer, bit-rate enable
// and word/frame boundary markers for FFT sample streaming.
module serial_shifter_param #(
   parameter int DATA_W    = 16,
   parameter int LSB_FIRST = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              ser_sow,
   output logic              ser_eow,
   output logic              ser_eof,
   output logic              busy
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

   logic [DATA_W-1:0] r_sh;
   logic [CW-1:0]     r_cnt;
   logic              r_active;
   logic              r_last;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_last;
   logic              r_hold_v;

   logic w_accept;
   logic w_word_end;
   logic w_load_slot;
   logic w_bit;

   assign w_accept    = in_valid && !r_hold_v;
   assign w_word_end  = r_active && (r_cnt == LAST_IDX);
   assign w_load_slot = !r_active || w_word_end;
   assign w_bit       = (LSB_FIRST != 0) ? r_sh[0] : r_sh[DATA_W-1];

   assign in_ready  = !r_hold_v;
   assign ser_out   = r_active ? w_bit : 1'b0;
   assign ser_valid = r_active;
   assign ser_sow   = r_active && (r_cnt == '0);
   assign ser_eow   = w_word_end;
   assign ser_eof   = w_word_end && r_last;
   assign busy      = r_active || r_hold_v;

   // Drain and fill of the holding buffer are mutually exclusive: an accept
   // is only possible while the buffer is empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh        <= '0;
         r_cnt       <= '0;
         r_active    <= 1'b0;
         r_last      <= 1'b0;
         r_hold      <= '0;
         r_hold_last <= 1'b0;
         r_hold_v    <= 1'b0;
      end else begin
         if (bit_en) begin
            if (w_load_slot && r_hold_v) begin
               r_sh     <= r_hold;
               r_last   <= r_hold_last;
               r_cnt    <= '0;
               r_active <= 1'b1;
               r_hold_v <= 1'b0;
            end else if (w_load_slot && w_accept) begin
               r_sh     <= in_data;
               r_last   <= in_last;
               r_cnt    <= '0;
               r_active <= 1'b1;
            end else if (w_load_slot) begin
               r_active <= 1'b0;
               r_cnt    <= '0;
            end else begin
               if (LSB_FIRST != 0) r_sh <= {1'b0, r_sh[DATA_W-1:1]};
               else                r_sh <= {r_sh[DATA_W-2:0], 1'b0};
               r_cnt <= r_cnt + 1'b1;
            end
         end
         if (w_accept && !(bit_en && w_load_slot)) begin
            r_hold      <= in_data;
            r_hold_last <= in_last;
            r_hold_v    <= 1'b1;
         end
      end
   end

endmodule
